// File: rtl/bomber_pkg.sv
// Shared types for the bomber player logic: direction and move-state enums,
// the 11-bit signed position type, and per-direction step helpers.
package bomber_pkg;

  localparam int unsigned POS_W    = 11;
  localparam int          TILE_DEF = 32;

  typedef logic signed [POS_W-1:0] pos_t;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    RETURN = 2'd2
  } move_state_t;

  // Signed X displacement of amt pixels in direction d.
  function automatic pos_t step_dx(input dir_t d, input pos_t amt);
    case (d)
      LEFT:    return -amt;
      RIGHT:   return amt;
      default: return '0;
    endcase
  endfunction

  // Signed Y displacement of amt pixels in direction d.
  function automatic pos_t step_dy(input dir_t d, input pos_t amt);
    case (d)
      UP:      return -amt;
      DOWN:    return amt;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/player_move_ctrl_tile_target_calc.sv
// Combinational next-tile target and legality for a requested direction.
// PLAYER_WRAP_EN: off-screen targets wrap, and the move starts one tile outside the opposite edge.
module tile_target_calc
  import bomber_pkg::*;
#(
  parameter int TILE  = TILE_DEF,
  parameter int X_MAX = 576,
  parameter int Y_MAX = 416
) (
  input  pos_t i_x,
  input  pos_t i_y,
  input  dir_t i_dir,
  output pos_t o_tgt_x,
  output pos_t o_tgt_y,
  output pos_t o_start_x,
  output pos_t o_start_y,
  output logic o_ok
);

  localparam pos_t TILE_P = pos_t'(TILE);
  localparam pos_t XMAX_P = pos_t'(X_MAX);
  localparam pos_t YMAX_P = pos_t'(Y_MAX);

  pos_t w_raw_x;
  pos_t w_raw_y;
  logic w_in_range;

  always_comb begin
    w_raw_x    = i_x + step_dx(i_dir, TILE_P);
    w_raw_y    = i_y + step_dy(i_dir, TILE_P);
    w_in_range = (w_raw_x >= 0) && (w_raw_x <= XMAX_P) &&
                 (w_raw_y >= 0) && (w_raw_y <= YMAX_P);
    o_tgt_x    = w_raw_x;
    o_tgt_y    = w_raw_y;
    o_start_x  = i_x;
    o_start_y  = i_y;
`ifdef PLAYER_WRAP_EN
    o_ok = 1'b1;
    // Re-enter from the far side: the object slides in from just beyond the edge.
    if (w_raw_x > XMAX_P) begin
      o_tgt_x   = '0;
      o_start_x = -TILE_P;
    end else if (w_raw_x < 0) begin
      o_tgt_x   = XMAX_P;
      o_start_x = XMAX_P + TILE_P;
    end
    if (w_raw_y > YMAX_P) begin
      o_tgt_y   = '0;
      o_start_y = -TILE_P;
    end else if (w_raw_y < 0) begin
      o_tgt_y   = YMAX_P;
      o_start_y = YMAX_P + TILE_P;
    end
`else
    o_ok = w_in_range;
`endif
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Tile-by-tile player movement with collision bounce-back, updated once per frame tick.
// PLAYER_WRAP_EN: moves past the playfield edge wrap to the opposite side.
module player_move_ctrl
  import bomber_pkg::*;
#(
  parameter int INIT_X = 32,
  parameter int INIT_Y = 32,
  parameter int TILE   = TILE_DEF,
  parameter int SPEED  = 4,
  parameter int X_MAX  = 576,
  parameter int Y_MAX  = 416
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               keyUp,
  input  logic               keyDown,
  input  logic               keyLeft,
  input  logic               keyRight,
  input  logic               collision,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               moving,
  output logic [1:0]         dir
);

  localparam pos_t TILE_P  = pos_t'(TILE);
  localparam pos_t SPEED_P = pos_t'(SPEED);
  localparam pos_t INIT_XP = pos_t'(INIT_X);
  localparam pos_t INIT_YP = pos_t'(INIT_Y);
`ifdef PLAYER_WRAP_EN
  localparam pos_t XMAX_P  = pos_t'(X_MAX);
  localparam pos_t YMAX_P  = pos_t'(Y_MAX);
`endif

  move_state_t r_state, w_nxt_state;
  dir_t        r_dir,   w_nxt_dir;
  pos_t        r_x, r_y, r_tgt_x, r_tgt_y;
  pos_t        w_nxt_x, w_nxt_y, w_nxt_tgt_x, w_nxt_tgt_y;
  logic        r_coll;
  logic        r_moving;

  logic        w_any_key;
  logic        w_flag;
  dir_t        w_key_dir;
  pos_t        w_calc_tgt_x, w_calc_tgt_y, w_calc_start_x, w_calc_start_y;
  logic        w_calc_ok;
  pos_t        w_step_x, w_step_y;

  tile_target_calc #(
    .TILE  (TILE),
    .X_MAX (X_MAX),
    .Y_MAX (Y_MAX)
  ) u_calc (
    .i_x       (r_x),
    .i_y       (r_y),
    .i_dir     (w_key_dir),
    .o_tgt_x   (w_calc_tgt_x),
    .o_tgt_y   (w_calc_tgt_y),
    .o_start_x (w_calc_start_x),
    .o_start_y (w_calc_start_y),
    .o_ok      (w_calc_ok)
  );

  // Next-state and next-position logic, evaluated for the coming frame tick.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_dir   = r_dir;
    w_nxt_x     = r_x;
    w_nxt_y     = r_y;
    w_nxt_tgt_x = r_tgt_x;
    w_nxt_tgt_y = r_tgt_y;
    w_any_key   = keyUp | keyDown | keyLeft | keyRight;
    w_flag      = r_coll | collision;
    w_key_dir   = keyUp ? UP : keyDown ? DOWN : keyLeft ? LEFT : RIGHT;
    w_step_x    = r_x + step_dx(r_dir, SPEED_P);
    w_step_y    = r_y + step_dy(r_dir, SPEED_P);

    case (r_state)
      IDLE: begin
        if (w_any_key) begin
          w_nxt_dir = w_key_dir;
          if (w_calc_ok) begin
            // The start tick already takes the first step.
            w_nxt_tgt_x = w_calc_tgt_x;
            w_nxt_tgt_y = w_calc_tgt_y;
            w_nxt_x     = w_calc_start_x + step_dx(w_key_dir, SPEED_P);
            w_nxt_y     = w_calc_start_y + step_dy(w_key_dir, SPEED_P);
            w_nxt_state = (w_nxt_x == w_calc_tgt_x && w_nxt_y == w_calc_tgt_y) ? IDLE : MOVING;
          end
        end
      end
      MOVING: begin
        if (w_flag) begin
          w_nxt_dir   = dir_t'(r_dir ^ 2'b01);
          w_nxt_tgt_x = r_tgt_x - step_dx(r_dir, TILE_P);
          w_nxt_tgt_y = r_tgt_y - step_dy(r_dir, TILE_P);
          w_nxt_state = RETURN;
        end else begin
          w_nxt_x     = w_step_x;
          w_nxt_y     = w_step_y;
          w_nxt_state = (w_step_x == r_tgt_x && w_step_y == r_tgt_y) ? IDLE : MOVING;
        end
      end
      RETURN: begin
        w_nxt_x = w_step_x;
        w_nxt_y = w_step_y;
        if (w_step_x == r_tgt_x && w_step_y == r_tgt_y) begin
          w_nxt_state = IDLE;
`ifdef PLAYER_WRAP_EN
          // A bounced wrap move lands off-screen; fold it back onto the playfield.
          if (w_step_x < 0)           w_nxt_x = w_step_x + XMAX_P + TILE_P;
          else if (w_step_x > XMAX_P) w_nxt_x = w_step_x - XMAX_P - TILE_P;
          if (w_step_y < 0)           w_nxt_y = w_step_y + YMAX_P + TILE_P;
          else if (w_step_y > YMAX_P) w_nxt_y = w_step_y - YMAX_P - TILE_P;
          w_nxt_tgt_x = w_nxt_x;
          w_nxt_tgt_y = w_nxt_y;
`endif
        end
      end
      default: w_nxt_state = IDLE;
    endcase
  end

  // Everything advances on the frame tick; the collision flag accumulates between ticks.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state  <= IDLE;
      r_dir    <= UP;
      r_x      <= INIT_XP;
      r_y      <= INIT_YP;
      r_tgt_x  <= INIT_XP;
      r_tgt_y  <= INIT_YP;
      r_coll   <= 1'b0;
      r_moving <= 1'b0;
    end else if (startOfFrame) begin
      r_state  <= w_nxt_state;
      r_dir    <= w_nxt_dir;
      r_x      <= w_nxt_x;
      r_y      <= w_nxt_y;
      r_tgt_x  <= w_nxt_tgt_x;
      r_tgt_y  <= w_nxt_tgt_y;
      r_coll   <= 1'b0;
      r_moving <= (w_nxt_state != IDLE);
    end else begin
      r_coll   <= r_coll | collision;
    end
  end

  assign topLeftX = r_x;
  assign topLeftY = r_y;
  assign moving   = r_moving;
  assign dir      = r_dir;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed self-checking bench for player_move_ctrl (default build, no wrap).
module tb_player_move_ctrl;

  logic               clk;
  logic               resetN;
  logic               startOfFrame;
  logic               keyUp, keyDown, keyLeft, keyRight;
  logic               collision;
  logic signed [10:0] topLeftX, topLeftY;
  logic               moving;
  logic [1:0]         dir;

  int n_chk;
  int n_pass;

  player_move_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .keyUp        (keyUp),
    .keyDown      (keyDown),
    .keyLeft      (keyLeft),
    .keyRight     (keyRight),
    .collision    (collision),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .moving       (moving),
    .dir          (dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic release_keys();
    keyUp = 1'b0; keyDown = 1'b0; keyLeft = 1'b0; keyRight = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    release_keys();
    collision = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // One frame tick: startOfFrame high for exactly one posedge, sample 1 ns later.
  task automatic tick();
    @(negedge clk);
    startOfFrame = 1'b1;
    @(posedge clk);
    #1;
    startOfFrame = 1'b0;
  endtask

  task automatic coll_pulse();
    @(negedge clk);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (topLeftX !== 11'sd32 || topLeftY !== 11'sd32) $display("FAIL reset_pos got (%0d,%0d) want (32,32)", topLeftX, topLeftY); else n_pass++;
    n_chk++; if (moving !== 1'b0 || dir !== 2'd0) $display("FAIL reset_flags got moving=%0b dir=%0d want 0/0", moving, dir); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_chk++;
      if (topLeftX !== 11'sd32 || topLeftY !== 11'sd32 || moving !== 1'b0 || dir !== 2'd0)
        $display("FAIL idle_tick%0d got (%0d,%0d) mv=%0b dir=%0d want (32,32) 0 0", i, topLeftX, topLeftY, moving, dir);
      else n_pass++;
    end
  endtask

  task automatic test_right_run();
    do_reset();
    keyRight = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_chk++;
      if (topLeftX !== 11'(32 + 4 * i) || topLeftY !== 11'sd32 || moving !== (i < 8) || dir !== 2'd3)
        $display("FAIL right_tick%0d got X=%0d Y=%0d mv=%0b dir=%0d want X=%0d Y=32 mv=%0b dir=3",
                 i, topLeftX, topLeftY, moving, dir, 32 + 4 * i, (i < 8));
      else n_pass++;
    end
    tick();
    n_chk++; if (topLeftX !== 11'sd68 || moving !== 1'b1) $display("FAIL right_repeat got X=%0d mv=%0b want X=68 mv=1", topLeftX, moving); else n_pass++;
    release_keys();
  endtask

  task automatic test_edge_reject();
    do_reset();
    keyUp = 1'b1;
    repeat (8) tick();
    n_chk++; if (topLeftY !== 11'sd0 || moving !== 1'b0) $display("FAIL up_to_top got Y=%0d mv=%0b want Y=0 mv=0", topLeftY, moving); else n_pass++;
    tick();
    n_chk++; if (topLeftY !== 11'sd0 || topLeftX !== 11'sd32 || moving !== 1'b0 || dir !== 2'd0)
      $display("FAIL up_reject got (%0d,%0d) mv=%0b dir=%0d want (32,0) 0 0", topLeftX, topLeftY, moving, dir); else n_pass++;
    release_keys();
    keyLeft = 1'b1;
    repeat (8) tick();
    n_chk++; if (topLeftX !== 11'sd0 || moving !== 1'b0) $display("FAIL left_to_edge got X=%0d mv=%0b want X=0 mv=0", topLeftX, moving); else n_pass++;
    release_keys();
    keyDown = 1'b1;
    tick();
    release_keys();
    repeat (7) tick();
    keyLeft = 1'b1;
    tick();
    n_chk++; if (topLeftX !== 11'sd0 || topLeftY !== 11'sd32 || moving !== 1'b0 || dir !== 2'd2)
      $display("FAIL left_reject got (%0d,%0d) mv=%0b dir=%0d want (0,32) 0 2", topLeftX, topLeftY, moving, dir); else n_pass++;
    release_keys();
  endtask

  task automatic test_priority();
    do_reset();
    keyRight = 1'b1;
    repeat (8) tick();
    release_keys();
    keyDown = 1'b1;
    repeat (8) tick();
    n_chk++; if (topLeftX !== 11'sd64 || topLeftY !== 11'sd64) $display("FAIL reach_64_64 got (%0d,%0d) want (64,64)", topLeftX, topLeftY); else n_pass++;
    keyLeft = 1'b1;
    tick();
    n_chk++; if (dir !== 2'd1 || topLeftY !== 11'sd68 || topLeftX !== 11'sd64) $display("FAIL prio_dir got dir=%0d (%0d,%0d) want 1 (64,68)", dir, topLeftX, topLeftY); else n_pass++;
    release_keys();
    repeat (7) tick();
    n_chk++; if (topLeftY !== 11'sd96 || topLeftX !== 11'sd64 || moving !== 1'b0) $display("FAIL prio_end got (%0d,%0d) mv=%0b want (64,96) 0", topLeftX, topLeftY, moving); else n_pass++;
  endtask

  task automatic test_collision();
    do_reset();
    keyRight = 1'b1;
    tick();
    release_keys();
    keyUp = 1'b1;
    tick();
    tick();
    n_chk++; if (topLeftX !== 11'sd44 || dir !== 2'd3) $display("FAIL keys_ignored got X=%0d dir=%0d want 44 3", topLeftX, dir); else n_pass++;
    release_keys();
    coll_pulse();
    tick();
    n_chk++; if (topLeftX !== 11'sd44 || dir !== 2'd2 || moving !== 1'b1) $display("FAIL bounce got X=%0d dir=%0d mv=%0b want 44 2 1", topLeftX, dir, moving); else n_pass++;
    tick();
    n_chk++; if (topLeftX !== 11'sd40 || moving !== 1'b1) $display("FAIL ret1 got X=%0d mv=%0b want 40 1", topLeftX, moving); else n_pass++;
    coll_pulse();
    tick();
    n_chk++; if (topLeftX !== 11'sd36 || dir !== 2'd2 || moving !== 1'b1) $display("FAIL ret_ignore got X=%0d dir=%0d mv=%0b want 36 2 1", topLeftX, dir, moving); else n_pass++;
    tick();
    n_chk++; if (topLeftX !== 11'sd32 || moving !== 1'b0 || dir !== 2'd2) $display("FAIL ret_home got X=%0d mv=%0b dir=%0d want 32 0 2", topLeftX, moving, dir); else n_pass++;
    // Collision coincident with the tick still counts for that tick.
    keyRight = 1'b1;
    tick();
    release_keys();
    @(negedge clk);
    collision = 1'b1;
    tick();
    collision = 1'b0;
    n_chk++; if (topLeftX !== 11'sd36 || dir !== 2'd2 || moving !== 1'b1) $display("FAIL same_cycle got X=%0d dir=%0d mv=%0b want 36 2 1", topLeftX, dir, moving); else n_pass++;
    tick();
    n_chk++; if (topLeftX !== 11'sd32 || moving !== 1'b0) $display("FAIL same_cycle_home got X=%0d mv=%0b want 32 0", topLeftX, moving); else n_pass++;
    // Collision while idle is discarded at the tick.
    coll_pulse();
    tick();
    keyRight = 1'b1;
    tick();
    release_keys();
    tick();
    n_chk++; if (topLeftX !== 11'sd40 || dir !== 2'd3 || moving !== 1'b1) $display("FAIL idle_coll got X=%0d dir=%0d mv=%0b want 40 3 1", topLeftX, dir, moving); else n_pass++;
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    keyRight = 1'b1;
    repeat (4) tick();
    n_chk++; if (topLeftX !== 11'sd48 || moving !== 1'b1) $display("FAIL pre_reset got X=%0d mv=%0b want 48 1", topLeftX, moving); else n_pass++;
    @(negedge clk);
    #1;
    resetN = 1'b0;
    #1;
    n_chk++; if (topLeftX !== 11'sd32 || topLeftY !== 11'sd32 || moving !== 1'b0 || dir !== 2'd0)
      $display("FAIL async_reset got (%0d,%0d) mv=%0b dir=%0d want (32,32) 0 0", topLeftX, topLeftY, moving, dir); else n_pass++;
    @(negedge clk);
    resetN = 1'b1;
    tick();
    n_chk++; if (topLeftX !== 11'sd36 || moving !== 1'b1 || dir !== 2'd3) $display("FAIL post_reset got X=%0d mv=%0b dir=%0d want 36 1 3", topLeftX, moving, dir); else n_pass++;
    release_keys();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    resetN = 1'b1;
    startOfFrame = 1'b0;
    collision = 1'b0;
    release_keys();
    test_reset();
    test_right_run();
    test_edge_reject();
    test_priority();
    test_collision();
    test_reset_mid_move();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/player_move_ctrl.md
PLAYER_MOVE_CTRL -- requirements
Module: player_move_ctrl

Interface
REQ-001 SHALL have parameter INIT_X, default 32, reset top-left X in pixels.
REQ-002 SHALL have parameter INIT_Y, default 32, reset top-left Y in pixels.
REQ-003 SHALL have parameter TILE, default 32, grid pitch in pixels.
REQ-004 SHALL have parameter SPEED, default 4, pixels moved per frame; TILE mod SPEED = 0.
REQ-005 SHALL have parameters X_MAX, default 576, and Y_MAX, default 416: largest legal top-left coordinates.
REQ-006 SHALL have port clk  input  1  system clock; the block has one clock.
REQ-007 SHALL have port resetN  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port startOfFrame  input  1  one-cycle pulse per VGA frame.
REQ-009 SHALL have port keyUp, keyDown, keyLeft, keyRight  input  1 each  level-sensitive key states.
REQ-010 SHALL have port collision  input  1  player/wall overlap pulse, any cycle.
REQ-011 SHALL have port topLeftX, topLeftY  output  signed 11 each  object position, feeding the square drawer.
REQ-012 SHALL have port moving  output  1  high in state MOVING or RETURN.
REQ-013 SHALL have port dir  output  2  current direction: 0 up, 1 down, 2 left, 3 right.

Function
REQ-014 SHALL update position, state, dir and the target only on the clk edge where startOfFrame=1 (frame tick); outputs are registered and change on that edge.
REQ-015 SHALL implement states IDLE, MOVING, RETURN.
REQ-016 IDLE, on a tick with any key high: SHALL pick dir with priority up>down>left>right; compute target = position ± TILE; enter MOVING only if target lies in [0, X_MAX] / [0, Y_MAX], otherwise stay IDLE with dir updated.
REQ-017 MOVING, on each tick: SHALL add ±SPEED to the moving axis; on reaching target, enter IDLE on that same tick.
REQ-018 SHALL latch collision into a sticky flag on any cycle; the flag is sampled and cleared on the tick.
REQ-019 MOVING with the flag set on a tick: SHALL, on that tick instead of stepping, swap target to origin tile, invert dir, enter RETURN.
REQ-020 RETURN: SHALL step ±SPEED toward origin each tick, ignore collision, enter IDLE on arrival.
REQ-021 SHALL ignore keys outside IDLE; a key held continuously repeats moves tile by tile with no idle tick gap beyond the arrival tick.
REQ-022 collision and startOfFrame in the same cycle: SHALL count as set for that tick.
REQ-023 Collision in IDLE: SHALL be cleared at the tick with no effect.
REQ-024 Position arithmetic SHALL be 11-bit signed; a position SHALL always be a TILE multiple in IDLE.

Reset
REQ-025 On resetN=0: topLeftX=INIT_X, topLeftY=INIT_Y, state IDLE, dir=0, moving=0, collision flag 0, target=(INIT_X, INIT_Y), asynchronously, including mid-move.
REQ-026 First tick after release SHALL behave as IDLE.

Configuration
REQ-027 Macro PLAYER_WRAP_EN: when defined, an out-of-range target SHALL wrap: moving past X_MAX enters at X=0 at the next tile, and the converse; Y likewise; movement is otherwise unchanged.
REQ-028 Without PLAYER_WRAP_EN: out-of-range targets SHALL be rejected per REQ-016.

Structure
REQ-029 Package bomber_pkg SHALL hold the dir_t enum (UP, DOWN, LEFT, RIGHT), the move_state_t enum, and the TILE default constant.
REQ-030 A sub-module tile_target_calc SHALL compute the target and the legality/wrap flag, combinationally.

Verification
REQ-031 Reset, then 3 ticks with no keys -> topLeft stays (32,32), moving=0, dir=0.
REQ-032 keyRight held for 8 ticks from (32,32) -> X=36,40,...,64 on ticks 1-8; moving drops on tick 8; a tick 9 with the key still held starts the next tile.
REQ-033 keyUp at (32,0) -> no move, dir=0; with PLAYER_WRAP_EN: target Y=416, first step Y=... wrap behaviour per REQ-027.
REQ-034 keyLeft+keyDown together at (64,64) -> dir=1, Y reaches 96 after 8 ticks, X unchanged.
REQ-035 collision pulse between ticks 3 and 4 of a right move from (32,32) -> tick 4 enters RETURN, dir=2, X 44->40->36->32, then IDLE.
REQ-036 resetN asserted mid-move at X=48 -> (32,32) immediately, IDLE; a collision pulse during RETURN -> no effect.
